// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scan driver family.
// Holds the nibble type, the all-off enable pattern and the leading-zero mask.
package seg_pkg;

   localparam int NIBBLE_W   = 4;
   localparam int MAX_DIGITS = 8;
   localparam int WIDE_W     = NIBBLE_W * MAX_DIGITS;

   typedef logic [NIBBLE_W-1:0] nibble_t;

   // Enables are active low, so all ones means every digit is dark.
   localparam logic [MAX_DIGITS-1:0] DIGIT_EN_OFF = '1;

   // Bit i is set when digit i is a leading zero that should stay dark.
   // Digit 0 is never masked, so a value of zero still shows a single "0".
   function automatic logic [MAX_DIGITS-1:0] leadZeroMask(
      input logic [WIDE_W-1:0] value,
      input int                numDigits,
      input logic              enable
   );
      logic [MAX_DIGITS-1:0] mask;
      logic                  allZero;
      mask    = '0;
      allZero = 1'b1;
      for (int i = MAX_DIGITS - 1; i > 0; i--) begin
         if (i < numDigits) begin
            allZero = allZero && (value[i*NIBBLE_W +: NIBBLE_W] == '0);
            mask[i] = allZero && enable;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Load handshake between the value source (status/debug logic) and the scan driver.
// The source holds valueIn steady while loadValid is high until loadReady is seen.
interface seg_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);
   import seg_pkg::*;

   logic [NIBBLE_W*NUM_DIGITS-1:0] valueIn;
   logic                           loadValid;
   logic                           loadReady;

   modport master (
      output valueIn,
      output loadValid,
      input  loadReady
   );

   modport slave (
      input  valueIn,
      input  loadValid,
      output loadReady
   );

endinterface

// File: rtl/seg_prescaler.sv
// Free-running modulo-PRESCALE counter with a wrap pulse on the terminal count.
// Used for digit slot timing; the enable makes it usable as a blink timebase too.
module seg_prescaler #(
   parameter int PRESCALE = 50000,
   localparam int CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable_i,
   output logic [CNT_W-1:0] count_o,
   output logic             wrap_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // wrap_o is combinational so the parent sees it in the same cycle as LAST.
   always_comb begin
      wrap_o  = enable_i && (count_q == LAST);
      count_d = count_q;
      if (enable_i) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scanner for a common-anode 7-segment bank: one nibble and one
// active-low digit enable per slot; new values only take effect at frame boundaries.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int PRESCALE      = 50000,
   parameter int DEAD          = 16,
   parameter int BLANK_LEADING = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   seg_scan_driver_if.slave      loadIf,
   input  logic                  blankAll,
   output logic [NIBBLE_W-1:0]   numOut,
   output logic [NUM_DIGITS-1:0] digitEn,
   output logic                  frameTick
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IDX_W = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);
   localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0]      DEAD_CNT = CNT_W'(DEAD);
   localparam logic [NUM_DIGITS-1:0] EN_OFF   = DIGIT_EN_OFF[NUM_DIGITS-1:0];

   logic [CNT_W-1:0]      slotCount;
   logic                  slotWrap;
   logic                  frameBoundary;
   logic                  accept;

   logic [IDX_W-1:0]      idx_q,        idx_d;
   logic [VAL_W-1:0]      shown_q,      shown_d;
   logic [VAL_W-1:0]      pending_q,    pending_d;
   logic                  pendValid_q,  pendValid_d;
   nibble_t               num_q,        num_d;
   logic [NUM_DIGITS-1:0] en_q,         en_d;
   logic                  tick_q,       tick_d;

   logic [MAX_DIGITS-1:0] suppressMask;
   logic                  lightOn;

   seg_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .enable_i (1'b1),
      .count_o  (slotCount),
      .wrap_o   (slotWrap)
   );

   // The pending slot frees up on the frame boundary, so a new load may land
   // in the same cycle the old pending value moves to the display.
   assign frameBoundary    = slotWrap && (idx_q == LAST_IDX);
   assign loadIf.loadReady = !pendValid_q || frameBoundary;
   assign accept           = loadIf.loadValid && loadIf.loadReady;

   always_comb begin
      idx_d       = idx_q;
      shown_d     = shown_q;
      pending_d   = pending_q;
      pendValid_d = pendValid_q;

      if (slotWrap) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end

      if (frameBoundary && pendValid_q) begin
         shown_d     = pending_q;
         pendValid_d = 1'b0;
      end

      // A fresh load always parks in pending, even on an empty-pending boundary.
      if (accept) begin
         pending_d   = loadIf.valueIn;
         pendValid_d = 1'b1;
      end
   end

   // Output stage: everything is derived from the current counter state and
   // registered, so the pins trail the counters by exactly one clock.
   always_comb begin
      suppressMask = leadZeroMask(WIDE_W'(shown_q), NUM_DIGITS, BLANK_LEADING != 0);
      lightOn      = ((DEAD == 0) || (slotCount >= DEAD_CNT))
                     && !blankAll
                     && !suppressMask[idx_q];

      num_d  = shown_q[idx_q*NIBBLE_W +: NIBBLE_W];
      en_d   = EN_OFF;
      tick_d = frameBoundary;
      if (lightOn) begin
         en_d[idx_q] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q       <= '0;
         shown_q     <= '0;
         pending_q   <= '0;
         pendValid_q <= 1'b0;
         num_q       <= '0;
         en_q        <= EN_OFF;
         tick_q      <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         shown_q     <= shown_d;
         pending_q   <= pending_d;
         pendValid_q <= pendValid_d;
         num_q       <= num_d;
         en_q        <= en_d;
         tick_q      <= tick_d;
      end
   end

   assign numOut    = num_q;
   assign digitEn   = en_q;
   assign frameTick = tick_q;

endmodule
